// File: rtl/lshift_seq.sv
// Sequential left shifter: one bit per clock, distance clamped to WIDTH, done pulse on completion.
// Optional carry output (last bit shifted out) enabled by defining LSHIFT_SEQ_CARRY_EN.
module lshift_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       distance,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
`ifdef LSHIFT_SEQ_CARRY_EN
    ,
    output logic             carry
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_work;
    logic [3:0]       r_count;
    logic [3:0]       w_k;
    logic             w_accept;
    logic [WIDTH-1:0] w_shifted;

    // Shift counts past WIDTH would only produce zeros, so clamp to bound latency.
    assign w_k       = (distance >= 4'(WIDTH)) ? 4'(WIDTH) : distance;
    assign w_accept  = start && (r_state != S_SHIFT);
    assign w_shifted = r_work << 1;

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_next = (w_k == 4'd0) ? S_DONE : S_SHIFT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_count == 4'd1) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_work  <= '0;
            r_count <= '0;
            out     <= '0;
        end else if (w_accept) begin
            r_work  <= in;
            r_count <= w_k;
            if (w_k == 4'd0) begin
                out <= in;
            end
        end else if (r_state == S_SHIFT) begin
            r_work  <= w_shifted;
            r_count <= r_count - 4'd1;
            if (r_count == 4'd1) begin
                out <= w_shifted;
            end
        end
    end

`ifdef LSHIFT_SEQ_CARRY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            carry <= 1'b0;
        end else if (w_accept) begin
            if (w_k == 4'd0) begin
                carry <= 1'b0;
            end
        end else if ((r_state == S_SHIFT) && (r_count == 4'd1)) begin
            carry <= r_work[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_lshift_seq.sv
// Scoreboard bench for lshift_seq (WIDTH=4): stimulus pushes expected results, a negedge monitor pops on done.
module tb_lshift_seq;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [3:0] distance;
    logic [3:0] din;
    logic [3:0] dout;
    logic       busy;
    logic       done;
`ifdef LSHIFT_SEQ_CARRY_EN
    logic       carry;
`endif

    lshift_seq #(.WIDTH(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .distance (distance),
        .in       (din),
        .out      (dout),
        .busy     (busy),
        .done     (done)
`ifdef LSHIFT_SEQ_CARRY_EN
        ,
        .carry    (carry)
`endif
    );

    typedef struct {
        logic [3:0] o;
        logic       c;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("out", int'(dout), int'(e.o));
                chk("done_cycle", cyc, e.cyc);
`ifdef LSHIFT_SEQ_CARRY_EN
                chk("carry", int'(carry), int'(e.c));
`endif
            end
        end
    end

    // Called on a negedge: present operands with start; accepting edge is the next posedge.
    task automatic issue(input logic [3:0] a, input logic [3:0] d,
                         input logic [3:0] eo, input logic ec, input int k,
                         input bit push);
        exp_t e;
        start    = 1'b1;
        din      = a;
        distance = d;
        if (push) begin
            e.o   = eo;
            e.c   = ec;
            e.cyc = cyc + 1 + k;
            q.push_back(e);
        end
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] d,
                       input logic [3:0] eo, input logic ec, input int k);
        issue(a, d, eo, ec, k, 1'b1);
        @(negedge clock);
        start    = 1'b0;
        din      = 4'hF;
        distance = 4'hF;
        for (int i = 0; i < k; i++) begin
            chk("busy_shift", int'(busy), 1);
            @(negedge clock);
        end
        chk("busy_done", int'(busy), 0);
        @(negedge clock);
        chk("idle_after_done", int'(done), 0);
        @(negedge clock);
        chk("out_hold", int'(dout), int'(eo));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        din      = '0;
        distance = '0;
        repeat (2) @(negedge clock);
        chk("rst_out", int'(dout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
`ifdef LSHIFT_SEQ_CARRY_EN
        chk("rst_carry", int'(carry), 0);
`endif
        reset_n = 1'b1;
        @(negedge clock);

        run(4'b0011, 4'd1,  4'b0110, 1'b0, 1);
        run(4'b1011, 4'd2,  4'b1100, 1'b0, 2);
        run(4'b1010, 4'd0,  4'b1010, 1'b0, 0);
        run(4'b0001, 4'd9,  4'b0000, 1'b1, 4);
        run(4'b0111, 4'd3,  4'b1000, 1'b1, 3);
        run(4'b1001, 4'd3,  4'b1000, 1'b0, 3);
        run(4'b0101, 4'd15, 4'b0000, 1'b1, 4);
        run(4'b0110, 4'd4,  4'b0000, 1'b0, 4);

        // Reset after the second shift edge of a 3-shift operation: no done expected.
        run(4'b0110, 4'd0, 4'b0110, 1'b0, 0);
        issue(4'b1111, 4'd3, 4'b0000, 1'b0, 3, 1'b0);
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("pre_reset_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("abort_out", int'(dout), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run(4'b0101, 4'd1, 4'b1010, 1'b0, 1);

        // Back-to-back with start held high; start during SHIFT must be ignored.
        issue(4'b0110, 4'd1, 4'b1100, 1'b0, 1, 1'b1);
        @(negedge clock);
        chk("b2b_busy1", int'(busy), 1);
        @(negedge clock);
        chk("b2b_in_done", int'(done), 1);
        issue(4'b0011, 4'd2, 4'b1100, 1'b0, 2, 1'b1);
        @(negedge clock);
        chk("b2b_busy2", int'(busy), 1);
        din      = 4'b1111;
        distance = 4'd0;
        @(negedge clock);
        chk("b2b_busy3", int'(busy), 1);
        start = 1'b0;
        @(negedge clock);
        chk("b2b_done2", int'(done), 1);
        repeat (3) @(negedge clock);
        chk("b2b_hold", int'(dout), 4'b1100);
        chk("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
